// File: rtl/sram_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_rr
// Description : N-client arbiter and timing controller for one external
//               asynchronous SRAM. Idle clients are skipped; arbitration is
//               round-robin or fixed-priority. All SRAM pins are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter_rr #(
    parameter int NUM_CLIENTS   = 2,
    parameter int ADDR_WIDTH    = 20,
    parameter int DATA_WIDTH    = 32,
    parameter int ACCESS_CYCLES = 2,
    parameter int FIXED_PRIO    = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            i_req_valid,
    input  logic [NUM_CLIENTS-1:0]            i_req_we,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] i_req_wdata,
    output logic [NUM_CLIENTS-1:0]            o_req_ready,
    output logic [NUM_CLIENTS-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]             o_rsp_rdata,
    output logic [ADDR_WIDTH-1:0]             o_sram_addr,
    output logic                              o_sram_ce_n,
    output logic                              o_sram_oe_n,
    output logic                              o_sram_we_n,
    inout  wire  [DATA_WIDTH-1:0]             io_sram_data
);

    localparam int              C_PW      = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [3:0]      C_LAST    = 4'(ACCESS_CYCLES - 1);
    localparam logic [C_PW-1:0] C_PTR_MAX = C_PW'(NUM_CLIENTS - 1);
    localparam logic [C_PW:0]   C_NUM     = (C_PW + 1)'(NUM_CLIENTS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [C_PW-1:0]         r_ptr;
    logic [C_PW-1:0]         r_owner;
    logic                    r_we;
    logic                    r_drive;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_ce_n;
    logic                    r_oe_n;
    logic                    r_we_n;
    logic [NUM_CLIENTS-1:0]  r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_window;
    logic                    w_found;
    logic [C_PW-1:0]         w_win;
    logic [C_PW:0]           w_sum;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic                    w_we;
    logic [NUM_CLIENTS-1:0]  w_ready;
    logic [NUM_CLIENTS-1:0]  w_owner_oh;
    logic                    w_last;

    // Arbitration may happen while idle or in the final cycle of an access,
    // so back-to-back accesses leave no dead cycle on the bus.
    assign w_last   = (r_state == ST_ACCESS) && (r_cnt == C_LAST);
    assign w_window = !rst && ((r_state == ST_IDLE) || (r_cnt == C_LAST));

    // Winner search: from the round-robin pointer with wrap, or from index 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (FIXED_PRIO != 0) begin
                w_sum = (C_PW + 1)'(k);
            end else begin
                w_sum = {1'b0, r_ptr} + (C_PW + 1)'(k);
                if (w_sum >= C_NUM) begin
                    w_sum = w_sum - C_NUM;
                end
            end
            if (!w_found && i_req_valid[w_sum[C_PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[C_PW-1:0];
            end
        end
    end

    // Select the winner's request fields and decode grant / owner one-hots.
    always_comb begin
        w_addr     = '0;
        w_wdata    = '0;
        w_we       = 1'b0;
        w_ready    = '0;
        w_owner_oh = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (w_win == C_PW'(k)) begin
                w_addr  = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata = i_req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
                w_we    = i_req_we[k];
            end
            w_ready[k]    = w_window && w_found && (w_win == C_PW'(k));
            w_owner_oh[k] = (r_owner == C_PW'(k));
        end
    end

    // Access FSM: grant capture, SRAM strobe timing and completion reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_we        <= 1'b0;
            r_drive     <= 1'b0;
            r_wdata     <= '0;
            r_addr      <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_rsp_valid <= '0;
            r_rdata     <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_last) begin
                r_rsp_valid <= w_owner_oh;
                if (!r_we) begin
                    r_rdata <= io_sram_data;
                end
            end
            if (w_window) begin
                if (w_found) begin
                    r_state <= ST_ACCESS;
                    r_cnt   <= '0;
                    r_owner <= w_win;
                    r_addr  <= w_addr;
                    r_we    <= w_we;
                    r_wdata <= w_wdata;
                    r_ce_n  <= 1'b0;
                    r_oe_n  <= w_we;
                    // First cycle of a write always strobes, including the 1-cycle case.
                    r_we_n  <= !w_we;
                    r_drive <= w_we;
                    if (FIXED_PRIO == 0) begin
                        r_ptr <= (w_win == C_PTR_MAX) ? '0 : w_win + 1'b1;
                    end
                end else begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_ce_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_drive <= 1'b0;
                end
            end else if (r_state == ST_ACCESS) begin
                r_cnt  <= r_cnt + 4'd1;
                // Release we_n for the final cycle so data is held past the strobe.
                r_we_n <= !(r_we && ((r_cnt + 4'd1) < C_LAST));
            end
        end
    end

    assign io_sram_data = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};
    assign o_req_ready  = w_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_rdata  = r_rdata;
    assign o_sram_addr  = r_addr;
    assign o_sram_ce_n  = r_ce_n;
    assign o_sram_oe_n  = r_oe_n;
    assign o_sram_we_n  = r_we_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter_rr
// Description : Scoreboard bench for sram_arbiter_rr. DUT A: 3 clients,
//               3-cycle round-robin. DUT B: 3 clients, 2-cycle fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter_rr;

    localparam int N  = 3;
    localparam int AW = 20;
    localparam int DW = 32;

    typedef struct {
        int          cl;
        bit          rd;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- DUT A ----------------
    logic [N-1:0]    va = '0, wea = '0, ready_a, rsp_a;
    logic [N*AW-1:0] addra = '0;
    logic [N*DW-1:0] wdataa = '0;
    logic [DW-1:0]   rdata_a;
    logic [AW-1:0]   saddr_a;
    logic            ce_a, oe_a, wen_a;
    wire  [DW-1:0]   bus_a;
    logic [DW-1:0]   mem_a [0:63];

    sram_arbiter_rr #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .ACCESS_CYCLES(3), .FIXED_PRIO(0)) u_dut_a (
        .clk(clk), .rst(rst),
        .i_req_valid(va), .i_req_we(wea), .i_req_addr(addra), .i_req_wdata(wdataa),
        .o_req_ready(ready_a), .o_rsp_valid(rsp_a), .o_rsp_rdata(rdata_a),
        .o_sram_addr(saddr_a), .o_sram_ce_n(ce_a), .o_sram_oe_n(oe_a),
        .o_sram_we_n(wen_a), .io_sram_data(bus_a));

    assign bus_a = (!ce_a && !oe_a && wen_a) ? mem_a[saddr_a[5:0]] : {DW{1'bz}};

    // SRAM A model: pattern preload on reset, write when strobed.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= 32'hA000_0000 + i;
        end else if (!ce_a && !wen_a) begin
            mem_a[saddr_a[5:0]] <= bus_a;
        end
    end

    // ---------------- DUT B ----------------
    logic [N-1:0]    vb = '0, web = '0, ready_b, rsp_b;
    logic [N*AW-1:0] addrb = '0;
    logic [N*DW-1:0] wdatab = '0;
    logic [DW-1:0]   rdata_b;
    logic [AW-1:0]   saddr_b;
    logic            ce_b, oe_b, wen_b;
    wire  [DW-1:0]   bus_b;

    sram_arbiter_rr #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .ACCESS_CYCLES(2), .FIXED_PRIO(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .i_req_valid(vb), .i_req_we(web), .i_req_addr(addrb), .i_req_wdata(wdatab),
        .o_req_ready(ready_b), .o_rsp_valid(rsp_b), .o_rsp_rdata(rdata_b),
        .o_sram_addr(saddr_b), .o_sram_ce_n(ce_b), .o_sram_oe_n(oe_b),
        .o_sram_we_n(wen_b), .io_sram_data(bus_b));

    assign bus_b = (!ce_b && !oe_b && wen_b && saddr_b == 20'h00123) ? 32'hDEAD_BEEF : {DW{1'bz}};

    // ---------------- scoreboard ----------------
    int   q_g_a[$], q_g_b[$];
    rsp_t q_r_a[$], q_r_b[$];
    int   gcyc_a[$], gcyc_b[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor A: pop expected grant/response whenever the DUT presents one.
    always @(negedge clk) begin
        if (!rst) begin
            if (|ready_a) begin
                int e;
                gcyc_a.push_back(cyc);
                chk("a_ready_onehot", 64'($onehot(ready_a)), 64'd1);
                if (q_g_a.size() == 0) chk("a_unexpected_grant", 64'(ready_a), 64'd0);
                else begin e = q_g_a.pop_front(); chk("a_grant", 64'(ready_a), 64'd1 << e); end
            end
            if (|rsp_a) begin
                rsp_t r;
                chk("a_rsp_onehot", 64'($onehot(rsp_a)), 64'd1);
                if (q_r_a.size() == 0) chk("a_unexpected_rsp", 64'(rsp_a), 64'd0);
                else begin
                    r = q_r_a.pop_front();
                    chk("a_rsp_client", 64'(rsp_a), 64'd1 << r.cl);
                    if (r.rd) chk("a_rsp_rdata", 64'(rdata_a), 64'(r.data));
                end
            end
        end
    end

    // Monitor B: same scheme for the fixed-priority instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (|ready_b) begin
                int e;
                gcyc_b.push_back(cyc);
                chk("b_ready_onehot", 64'($onehot(ready_b)), 64'd1);
                if (q_g_b.size() == 0) chk("b_unexpected_grant", 64'(ready_b), 64'd0);
                else begin e = q_g_b.pop_front(); chk("b_grant", 64'(ready_b), 64'd1 << e); end
            end
            if (|rsp_b) begin
                rsp_t r;
                chk("b_rsp_onehot", 64'($onehot(rsp_b)), 64'd1);
                if (q_r_b.size() == 0) chk("b_unexpected_rsp", 64'(rsp_b), 64'd0);
                else begin
                    r = q_r_b.pop_front();
                    chk("b_rsp_client", 64'(rsp_b), 64'd1 << r.cl);
                    if (r.rd) chk("b_rsp_rdata", 64'(rdata_b), 64'(r.data));
                end
            end
        end
    end

    task automatic req_a(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        va[c] = 1'b1; wea[c] = we; addra[c*AW +: AW] = a; wdataa[c*DW +: DW] = d;
    endtask

    task automatic req_b(input int c, input logic [AW-1:0] a);
        vb[c] = 1'b1; web[c] = 1'b0; addrb[c*AW +: AW] = a;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base_a, base_b, n;

        // 1. reset state, then idle with no requests
        cycles(2);
        chk("rst_ce_a", 64'(ce_a), 64'd1);
        chk("rst_oe_a", 64'(oe_a), 64'd1);
        chk("rst_we_a", 64'(wen_a), 64'd1);
        chk("rst_addr_a", 64'(saddr_a), 64'd0);
        chk("rst_ready_a", 64'(ready_a), 64'd0);
        chk("rst_rsp_a", 64'(rsp_a), 64'd0);
        chk("rst_rdata_b", 64'(rdata_b), 64'd0);
        chk("rst_ce_b", 64'(ce_b), 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        cycles(3);
        chk("idle_ce_a", 64'(ce_a), 64'd1);
        chk("idle_ready_b", 64'(ready_b), 64'd0);

        // 2. B client 0 read of 0x00123, 2-cycle access
        @(posedge clk); #1;
        req_b(0, 20'h00123);
        q_g_b.push_back(0);
        q_r_b.push_back('{cl: 0, rd: 1'b1, data: 32'hDEAD_BEEF});
        @(negedge clk); chk("t2_ready_t", 64'(ready_b), 64'd1);
        @(posedge clk); #1 vb[0] = 1'b0;
        @(negedge clk); chk("t2_oe_t1", 64'(oe_b), 64'd0); chk("t2_ce_t1", 64'(ce_b), 64'd0);
        @(negedge clk); chk("t2_oe_t2", 64'(oe_b), 64'd0); chk("t2_we_t2", 64'(wen_b), 64'd1);
        @(negedge clk); chk("t2_rsp_t3", 64'(rsp_b), 64'd1);
        chk("t2_rdata", 64'(rdata_b), 64'hDEAD_BEEF); chk("t2_idle_oe", 64'(oe_b), 64'd1);

        // 3. A client 1 write 0x55AA55AA to 0x10, 3-cycle access, then read back
        @(posedge clk); #1;
        req_a(1, 1'b1, 20'h00010, 32'h55AA_55AA);
        q_g_a.push_back(1);
        q_r_a.push_back('{cl: 1, rd: 1'b0, data: 32'h0});
        @(negedge clk); chk("t3_ready", 64'(ready_a), 64'b010);
        @(posedge clk); #1 va[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_we_n", 64'(wen_a), (i < 2) ? 64'd0 : 64'd1);
            chk("t3_oe_n", 64'(oe_a), 64'd1);
            chk("t3_bus", 64'(bus_a), 64'h55AA_55AA);
        end
        @(negedge clk); chk("t3_rsp", 64'(rsp_a), 64'b010);
        @(posedge clk); #1;
        req_a(0, 1'b0, 20'h00010, 32'h0);
        q_g_a.push_back(0);
        q_r_a.push_back('{cl: 0, rd: 1'b1, data: 32'h55AA_55AA});
        @(negedge clk); chk("t3_rb_ready", 64'(ready_a), 64'b001);
        @(posedge clk); #1 va[0] = 1'b0;
        cycles(4);
        chk("t3_rb_rdata", 64'(rdata_a), 64'h55AA_55AA);

        // 5. only client 2 requests (pointer at 1): granted at once
        @(posedge clk); #1;
        req_a(2, 1'b0, 20'h00002, 32'h0);
        q_g_a.push_back(2);
        q_r_a.push_back('{cl: 2, rd: 1'b1, data: 32'hA000_0002});
        @(negedge clk); chk("t5_ready", 64'(ready_a), 64'b100);
        @(posedge clk); #1 va[2] = 1'b0;
        cycles(5);

        // 4. all clients hold requests: RR on A, fixed priority on B
        base_a = gcyc_a.size();
        base_b = gcyc_b.size();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < N; c++) begin
                q_g_a.push_back(c);
                q_r_a.push_back('{cl: c, rd: 1'b1, data: 32'hA000_0000 + c});
                q_g_b.push_back(0);
                q_r_b.push_back('{cl: 0, rd: 1'b1, data: 32'hDEAD_BEEF});
            end
        end
        @(posedge clk); #1;
        for (int c = 0; c < N; c++) begin
            req_a(c, 1'b0, AW'(c), 32'h0);
            req_b(c, 20'h00123);
        end
        n = 0;
        while ((va != 0 || vb != 0) && n < 60) begin
            @(posedge clk); #1;
            if (gcyc_a.size() - base_a >= 6) va = '0;
            if (gcyc_b.size() - base_b >= 6) vb = '0;
            n++;
        end
        if (n >= 60) chk("t4_timeout", 64'd1, 64'd0);
        cycles(8);
        if (gcyc_a.size() - base_a >= 6 && gcyc_b.size() - base_b >= 6) begin
            for (int i = 1; i < 6; i++) begin
                chk("t4_rr_spacing", 64'(gcyc_a[base_a+i] - gcyc_a[base_a+i-1]), 64'd3);
                chk("t4_fp_spacing", 64'(gcyc_b[base_b+i] - gcyc_b[base_b+i-1]), 64'd2);
            end
        end else begin
            chk("t4_grant_count", 64'(gcyc_a.size() - base_a), 64'd6);
        end

        // 6. reset during the first cycle of a write
        @(posedge clk); #1;
        req_a(1, 1'b1, 20'h00020, 32'h1234_5678);
        q_g_a.push_back(1);
        @(negedge clk); chk("t6_ready", 64'(ready_a), 64'b010);
        @(posedge clk); #1 va[1] = 1'b0;
        chk("t6_we_low", 64'(wen_a), 64'd0);
        #1 rst = 1'b1;
        #1;
        chk("t6_we_async", 64'(wen_a), 64'd1);
        chk("t6_ce_async", 64'(ce_a), 64'd1);
        chk("t6_rsp_none", 64'(rsp_a), 64'd0);
        cycles(2);
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < N; c++) req_a(c, 1'b0, AW'(c), 32'h0);
        q_g_a.push_back(0);
        q_r_a.push_back('{cl: 0, rd: 1'b1, data: 32'hA000_0000});
        @(negedge clk); chk("t6_ptr_reset", 64'(ready_a), 64'b001);
        @(posedge clk); #1 va = '0;
        cycles(6);

        chk("drain_grant_a", 64'(q_g_a.size()), 64'd0);
        chk("drain_rsp_a", 64'(q_r_a.size()), 64'd0);
        chk("drain_grant_b", 64'(q_g_b.size()), 64'd0);
        chk("drain_rsp_b", 64'(q_r_b.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
